simmem_rdata_responder: RTL and testbench

- Read-side responder at the memory end of the simmem AXI path.
- Accepts raddr_req_t requests and charges a DRAM-style row-buffer latency: row hit, precharge plus activation, or activation only.
- Returns the read burst as rdata_t beats, with deterministic data and the request id.
- Serves as the memory model that the simmem delay banks sit in front of, and as the bench target for them.

---
 rtl/simmem_pkg.sv | 38 +++
 rtl/simmem_row_cost.sv | 23 ++
 rtl/simmem_rdata_responder.sv | 137 +++++++++++++
 tb/tb_simmem_rdata_responder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/simmem_pkg.sv
// Shared simmem types and parameters: AXI-side request/response payloads and
// DRAM row-buffer timing defaults used by the memory-end responders.
package simmem_pkg;

    localparam int unsigned AxAddrWidth       = 16;
    localparam int unsigned RowBufferLenWidth = 8;
    localparam int unsigned RowAddrWidth      = AxAddrWidth - RowBufferLenWidth;
    localparam int unsigned IdWidth           = 4;
    localparam int unsigned AxLenWidth        = 8;
    localparam int unsigned XDataWidth        = 14;
    localparam int unsigned XRespWidth        = 2;
    localparam int unsigned MaxRBurstLen      = 4;
    localparam int unsigned MaxReadBurstWidth = $clog2(MaxRBurstLen);

    localparam int unsigned RowHitCost     = 10;
    localparam int unsigned PrechargeCost  = 50;
    localparam int unsigned ActivationCost = 45;

    typedef struct packed {
        logic [IdWidth-1:0]     id;
        logic [AxAddrWidth-1:0] addr;
        logic [AxLenWidth-1:0]  burst_length;
    } raddr_req_t;

    typedef struct packed {
        logic [IdWidth-1:0]    id;
        logic [XDataWidth-1:0] data;
        logic [XRespWidth-1:0] response;
        logic                  last;
    } rdata_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } rdata_responder_state_e;

endpackage

// File: rtl/simmem_row_cost.sv
// Row-buffer access latency: activation only when no row is open, hit cost for
// the open row, otherwise precharge of the old row plus activation of the new.
module simmem_row_cost #(
    parameter int unsigned RowHitCost     = simmem_pkg::RowHitCost,
    parameter int unsigned PrechargeCost  = simmem_pkg::PrechargeCost,
    parameter int unsigned ActivationCost = simmem_pkg::ActivationCost,
    parameter int unsigned CostWidth      = 8
) (
    input  logic [simmem_pkg::RowAddrWidth-1:0] row,
    input  logic [simmem_pkg::RowAddrWidth-1:0] open_row,
    input  logic                                row_open,
    output logic [CostWidth-1:0]                cost
);

    always_comb begin
        cost = CostWidth'(ActivationCost);
        if (row_open) begin
            cost = (row == open_row) ? CostWidth'(RowHitCost)
                                     : CostWidth'(PrechargeCost + ActivationCost);
        end
    end

endmodule

// File: rtl/simmem_rdata_responder.sv
// Memory-end read responder: charges a row-buffer latency per request, then
// streams the burst as deterministic data beats carrying the request id.
module simmem_rdata_responder #(
    parameter int unsigned RowHitCost     = simmem_pkg::RowHitCost,
    parameter int unsigned PrechargeCost  = simmem_pkg::PrechargeCost,
    parameter int unsigned ActivationCost = simmem_pkg::ActivationCost,
    parameter int unsigned CostWidth      = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  simmem_pkg::raddr_req_t raddr_i,
    input  logic                   raddr_valid_i,
    output logic                   raddr_ready_o,
    output simmem_pkg::rdata_t     rdata_o,
    output logic                   rdata_valid_o,
    input  logic                   rdata_ready_i
);

    import simmem_pkg::*;

    rdata_responder_state_e state_q, state_d;

    logic [CostWidth-1:0]         wait_cnt_q, wait_cnt_d;
    logic [MaxReadBurstWidth-1:0] beat_idx_q, beat_idx_d;
    logic [MaxReadBurstWidth-1:0] len_q, len_d;
    logic [IdWidth-1:0]           id_q, id_d;
    logic [AxAddrWidth-1:0]       addr_q, addr_d;
    logic [RowAddrWidth-1:0]      open_row_q, open_row_d;
    logic                         row_open_q, row_open_d;

    logic [RowAddrWidth-1:0]      req_row;
    logic [CostWidth-1:0]         req_cost;
    rdata_t                       rdata_d;
    logic                         rdata_valid_d;
    logic                         raddr_ready_d;
    logic                         unused_len_bits;

    assign req_row = raddr_i.addr[AxAddrWidth-1:RowBufferLenWidth];
    // Only the low length bits select the beat count; the rest are ignored.
    assign unused_len_bits = ^raddr_i.burst_length[AxLenWidth-1:MaxReadBurstWidth];

    simmem_row_cost #(
        .RowHitCost     (RowHitCost),
        .PrechargeCost  (PrechargeCost),
        .ActivationCost (ActivationCost),
        .CostWidth      (CostWidth)
    ) u_row_cost (
        .row      (req_row),
        .open_row (open_row_q),
        .row_open (row_open_q),
        .cost     (req_cost)
    );

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        beat_idx_d = beat_idx_q;
        len_d      = len_q;
        id_d       = id_q;
        addr_d     = addr_q;
        open_row_d = open_row_q;
        row_open_d = row_open_q;

        unique case (state_q)
            IDLE: begin
                if (raddr_valid_i) begin
                    state_d    = WAIT;
                    id_d       = raddr_i.id;
                    addr_d     = raddr_i.addr;
                    len_d      = raddr_i.burst_length[MaxReadBurstWidth-1:0];
                    wait_cnt_d = req_cost - CostWidth'(1);
                    open_row_d = req_row;
                    row_open_d = 1'b1;
                end
            end
            WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d = SEND;
                end else begin
                    wait_cnt_d = wait_cnt_q - CostWidth'(1);
                end
            end
            SEND: begin
                if (rdata_ready_i) begin
                    if (beat_idx_q == len_q) begin
                        state_d    = IDLE;
                        beat_idx_d = '0;
                    end else begin
                        beat_idx_d = beat_idx_q + MaxReadBurstWidth'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are built from the upcoming state.
        rdata_d       = '0;
        rdata_valid_d = (state_d == SEND);
        raddr_ready_d = (state_d == IDLE);
        if (state_d == SEND) begin
            rdata_d.id       = id_q;
            rdata_d.data     = XDataWidth'(addr_q + AxAddrWidth'(beat_idx_d));
            rdata_d.response = '0;
            rdata_d.last     = (beat_idx_d == len_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            wait_cnt_q    <= '0;
            beat_idx_q    <= '0;
            len_q         <= '0;
            id_q          <= '0;
            addr_q        <= '0;
            open_row_q    <= '0;
            row_open_q    <= 1'b0;
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
            raddr_ready_o <= 1'b1;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            beat_idx_q    <= beat_idx_d;
            len_q         <= len_d;
            id_q          <= id_d;
            addr_q        <= addr_d;
            open_row_q    <= open_row_d;
            row_open_q    <= row_open_d;
            rdata_o       <= rdata_d;
            rdata_valid_o <= rdata_valid_d;
            raddr_ready_o <= raddr_ready_d;
        end
    end

endmodule

// File: tb/tb_simmem_rdata_responder.sv
// Directed bench for simmem_rdata_responder: expected beats are queued when a
// request is issued and popped as the responder streams them out.
module tb_simmem_rdata_responder;

    import simmem_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    raddr_req_t raddr;
    logic       raddr_valid;
    logic       raddr_ready;
    rdata_t     rdata;
    logic       rdata_valid;
    logic       rdata_ready;

    rdata_t     exp_q[$];
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    simmem_rdata_responder dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .raddr_i       (raddr),
        .raddr_valid_i (raddr_valid),
        .raddr_ready_o (raddr_ready),
        .rdata_o       (rdata),
        .rdata_valid_o (rdata_valid),
        .rdata_ready_i (rdata_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic rdata_t model_beat(input logic [3:0] id, input logic [15:0] addr,
                                          input logic [7:0] len, input int i);
        rdata_t e;
        int     n;
        n          = int'(len[1:0]) + 1;
        e.id       = id;
        e.data     = 14'((int'(addr) + i) % 16384);
        e.response = 2'b00;
        e.last     = (i == n - 1);
        return e;
    endfunction

    task automatic push_beats(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len);
        for (int i = 0; i <= int'(len[1:0]); i++) exp_q.push_back(model_beat(id, addr, len, i));
    endtask

    // Entered #1 after a rising edge; leaves #1 after the acceptance edge.
    task automatic accept(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input string tag);
        raddr.id           = id;
        raddr.addr         = addr;
        raddr.burst_length = len;
        raddr_valid        = 1'b1;
        check({tag, "_ready_idle"}, 64'(raddr_ready), 64'd1);
        @(posedge clk);
        #1;
        raddr_valid = 1'b0;
        check({tag, "_ready_drop"}, 64'(raddr_ready), 64'd0);
    endtask

    task automatic wait_first(input int exp_cost, input string tag);
        int cyc = 0;
        while (!rdata_valid && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(exp_cost));
    endtask

    task automatic drain(input int n_beats, input int stall_beat, input int stall_cycles,
                         input string tag);
        rdata_t e;
        int     hs = 0;
        for (int i = 0; i < n_beats; i++) begin
            if (exp_q.size() == 0) begin
                check({tag, "_queue_underflow"}, 64'(i), 64'(n_beats));
                break;
            end
            e = exp_q.pop_front();
            check($sformatf("%s_beat%0d_valid", tag, i), 64'(rdata_valid), 64'd1);
            check($sformatf("%s_beat%0d_data", tag, i), 64'(rdata), 64'(e));
            if (i == stall_beat) begin
                rdata_ready = 1'b0;
                for (int k = 0; k < stall_cycles; k++) begin
                    @(posedge clk);
                    #1;
                    check($sformatf("%s_stall%0d_valid", tag, k), 64'(rdata_valid), 64'd1);
                    check($sformatf("%s_stall%0d_data", tag, k), 64'(rdata), 64'(e));
                end
                rdata_ready = 1'b1;
            end
            if (rdata_valid && rdata_ready) hs++;
            @(posedge clk);
            #1;
        end
        check({tag, "_handshakes"}, 64'(hs), 64'(n_beats));
        check({tag, "_valid_after"}, 64'(rdata_valid), 64'd0);
        check({tag, "_ready_after"}, 64'(raddr_ready), 64'd1);
        check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_req(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input int exp_cost, input int stall_beat, input int stall_cycles,
                          input string tag);
        push_beats(id, addr, len);
        accept(id, addr, len, tag);
        wait_first(exp_cost, tag);
        drain(int'(len[1:0]) + 1, stall_beat, stall_cycles, tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rvalid"}, 64'(rdata_valid), 64'd0);
        check({tag, "_aready"}, 64'(raddr_ready), 64'd1);
        check({tag, "_rdata"}, 64'(rdata), 64'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        raddr       = '0;
        raddr_valid = 1'b0;
        rdata_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_req(4'd3, 16'h1230, 8'h00, 45, -1, 0, "cold");
        do_req(4'd5, 16'h1240, 8'h03, 10, -1, 0, "hit");
        do_req(4'd9, 16'h3400, 8'h01, 95, -1, 0, "miss");
        do_req(4'd6, 16'h3410, 8'h03, 10,  1, 7, "bp");
        do_req(4'd7, 16'h3FFF, 8'hFF, 95, -1, 0, "wrap");

        // Reset while waiting on a row that would otherwise hit.
        accept(4'd1, 16'h3F00, 8'h02, "rst_wait");
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_in_wait");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Row state was invalidated: same row is a cold access; reset mid-burst.
        accept(4'd1, 16'h3F00, 8'h02, "rst_send");
        wait_first(45, "rst_send");
        check("rst_send_first_beat", 64'(rdata), 64'(model_beat(4'd1, 16'h3F00, 8'h02, 0)));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_in_send");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_req(4'd2, 16'h3F00, 8'h03, 45, -1, 0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
